umi_pack_buf: RTL

Registered UMI packet packer: accepts decoded transaction fields (opcode, size, options, addresses, data) over a valid/ready handshake and emits a UMI packet (cmd, src addr, dst addr, payload) over a second valid/ready handshake. It is the transmit-side counterpart of the field unpacker. It sits between a host or agent request generator and the UMI fabric port. A two-entry skid buffer provides full throughput and registered ready.

---
 rtl/umi_pkg.sv | 36 +++
 rtl/umi_pack.sv | 32 +++
 rtl/umi_pack_buf.sv | 115 +++++++++++
 3 files changed

// File: rtl/umi_pkg.sv
// Shared UMI field layout, size limit and packet struct used by the packer and its skid buffer.
package umi_pkg;

    localparam int UMI_AW = 64;
    localparam int UMI_CW = 32;
    localparam int UMI_UW = 256;

    localparam int CMD_OPCODE_LSB  = 0;
    localparam int CMD_OPCODE_MSB  = 7;
    localparam int CMD_SIZE_LSB    = 8;
    localparam int CMD_SIZE_MSB    = 11;
    localparam int CMD_OPTIONS_LSB = 12;
    localparam int CMD_OPTIONS_MSB = 31;

    // log2 of the payload width in bytes; anything larger cannot be carried
    localparam logic [3:0] UMI_MAX_SIZE = 4'd5;

    typedef struct packed {
        logic [UMI_CW-1:0] cmd;
        logic [UMI_AW-1:0] dst;
        logic [UMI_AW-1:0] src;
        logic [UMI_UW-1:0] payload;
    } umi_pkt_t;

    // encoding is {main_v, skid_v}
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_e;

    function automatic logic size_legal(input logic [3:0] size);
        return size <= UMI_MAX_SIZE;
    endfunction

endpackage

// File: rtl/umi_pack.sv
// Combinational field-to-packet assembly. With UMI_PACK_MASK_EN defined, payload
// bytes beyond 2^size are zeroed; otherwise the payload passes through untouched.
module umi_pack
    import umi_pkg::*;
(
    input  logic [7:0]        command_i,
    input  logic [3:0]        size_i,
    input  logic [19:0]       options_i,
    input  logic [UMI_AW-1:0] dstaddr_i,
    input  logic [UMI_AW-1:0] srcaddr_i,
    input  logic [UMI_UW-1:0] data_i,
    output umi_pkt_t          pkt_o
);

    always_comb begin
        pkt_o = '0;
        pkt_o.cmd[CMD_OPCODE_MSB:CMD_OPCODE_LSB]   = command_i;
        pkt_o.cmd[CMD_SIZE_MSB:CMD_SIZE_LSB]       = size_i;
        pkt_o.cmd[CMD_OPTIONS_MSB:CMD_OPTIONS_LSB] = options_i;
        pkt_o.dst     = dstaddr_i;
        pkt_o.src     = srcaddr_i;
        pkt_o.payload = data_i;
`ifdef UMI_PACK_MASK_EN
        for (int b = 0; b < UMI_UW / 8; b++) begin
            if (b >= (1 << size_i)) begin
                pkt_o.payload[8*b +: 8] = 8'h00;
            end
        end
`endif
    end

endmodule

// File: rtl/umi_pack_buf.sv
// Registered UMI packet packer with a two-entry skid buffer (registered in_ready).
// Optional payload byte masking is enabled by defining UMI_PACK_MASK_EN.
module umi_pack_buf
    import umi_pkg::*;
#(
    parameter int AW = 64,
    parameter int CW = 32,
    parameter int UW = 256
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    command,
    input  logic [3:0]    size,
    input  logic [19:0]   options,
    input  logic [AW-1:0] dstaddr,
    input  logic [AW-1:0] srcaddr,
    input  logic [UW-1:0] data,
    output logic          packet_valid,
    input  logic          packet_ready,
    output logic [CW-1:0] packet_cmd,
    output logic [AW-1:0] packet_dst_addr,
    output logic [AW-1:0] packet_src_addr,
    output logic [UW-1:0] packet_payload,
    output logic [15:0]   drop_count
);

    buf_state_e  state_q, state_d;
    umi_pkt_t    pkt_in;
    umi_pkt_t    main_q, main_d;
    umi_pkt_t    skid_q, skid_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        main_v, skid_v;
    logic        in_fire, acc, drop, pop;

    umi_pack u_pack (
        .command_i (command),
        .size_i    (size),
        .options_i (options),
        .dstaddr_i (dstaddr),
        .srcaddr_i (srcaddr),
        .data_i    (data),
        .pkt_o     (pkt_in)
    );

    assign main_v  = state_q[1];
    assign skid_v  = state_q[0];
    assign in_fire = in_valid & ~skid_v;
    assign acc     = in_fire & size_legal(size);
    assign drop    = in_fire & ~size_legal(size);
    assign pop     = main_v & packet_ready;

    // Illegal requests are consumed without touching the stored entries.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (acc) begin
                    state_d = BUF_ONE;
                    main_d  = pkt_in;
                end
            end
            BUF_ONE: begin
                if (acc && pop) begin
                    main_d = pkt_in;
                end else if (acc) begin
                    state_d = BUF_FULL;
                    skid_d  = pkt_in;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    state_d = BUF_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= BUF_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign in_ready        = ~skid_v;
    assign packet_valid    = main_v;
    assign packet_cmd      = main_q.cmd;
    assign packet_dst_addr = main_q.dst;
    assign packet_src_addr = main_q.src;
    assign packet_payload  = main_q.payload;
    assign drop_count      = drop_count_q;

endmodule
